uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the mini-spart serial transmitter. It has a configurable frame format: data width, optional even/odd parity, and 1 or 2 stop bits. A small write FIFO decouples the bus interface from the serial line, so back-to-back frames go out with no idle gap. It sits between the bus interface/driver logic and the TxD pin, and it consumes the shared baud-generator enable tick.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
OVERSAMPLE, 16, baud `en` ticks per serial bit; legal range 4..16.
FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
en  in  1  baud enable tick, one clk wide, from the baud generator.
wr_en  in  1  write strobe; pushes `data` into the FIFO.
data  in  DATA_BITS  byte to transmit; LSB is sent first.
parity_en  in  1  when 1, a parity bit follows the data bits.
parity_odd  in  1  0 = even parity, 1 = odd parity.
two_stop  in  1  0 = one stop bit, 1 = two stop bits.
tbr  out  1  transmit buffer ready: FIFO not full.
busy  out  1  a frame is on the line or the FIFO is non-empty.
ovf  out  1  one-cycle pulse when a write is dropped.
TxD  out  1  serial output; idle level is 1.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO flushed and state=IDLE.
  - Output values during reset: TxD=1, tbr=1, busy=0, ovf=0.
  - Asserting reset mid-frame forces TxD=1 immediately; that frame and all queued data are lost.
- FIFO write:
  - wr_en with FIFO not full: data is pushed, and tbr updates on the next edge.
  - wr_en with FIFO full and no pop in the same cycle: write dropped, FIFO unchanged, ovf=1 in the next cycle.
  - wr_en with FIFO full and a pop in the same cycle: the write is accepted and ovf stays 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - If the FIFO is non-empty: pop the head entry into the shift register.
  - At the same edge, latch parity_en, parity_odd and two_stop into frame-config registers, then go to START.
  - TxD=0 from the cycle after the pop.
  - Configuration inputs are ignored mid-frame.
- Bit timing:
  - Each bit is held for exactly OVERSAMPLE `en` ticks.
  - The tick counter loads OVERSAMPLE-1 on bit entry and decrements on each `en`.
  - On the `en` that finds the counter at 0, the FSM advances to the next bit (next clk edge).
  - Cycles without `en` never change state.
- START: TxD=0 for one bit time, then DATA.
- DATA:
  - TxD = shift register bit 0; the register shifts right once per bit.
  - The bit counter loads DATA_BITS-1.
  - After the last data bit: go to PARITY if parity_en was latched, else STOP.
- PARITY:
  - TxD = XOR of all DATA_BITS data bits, XOR the latched parity_odd.
  - The parity value is computed at pop time.
- STOP:
  - TxD=1 for 1 bit time, or 2 if two_stop was latched.
  - At the end of the stop time: if the FIFO is non-empty, pop and enter START on the same edge (no idle bit); else go to IDLE.
- busy = (state != IDLE) or (FIFO count != 0).
- Frame length in `en` ticks: OVERSAMPLE*(1 + DATA_BITS + parity_en + 1 + two_stop).
- Widths:
  - Tick counter: $clog2(OVERSAMPLE) bits.
  - Bit counter: 3 bits.
  - FIFO pointers: $clog2(FIFO_DEPTH) bits with wrap-around; count is one bit wider.
- `en` asserted while in IDLE has no effect. A frame's first tick counts from the first `en` after entering START.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the constant TX_IDLE_LEVEL=1'b1;
  - a localparam function computing frame length.
- One sub-module: sync_fifo (parametrised WIDTH and DEPTH; push, pop, full, empty, count). It is reusable by the future receive path.

Test Plan:
- Basic frame (OVERSAMPLE=16, 8N1): write 0x55 -> TxD line sequence 0,1,0,1,0,1,0,1,0,1, each bit held 16 `en` ticks; busy drops after 160 ticks; tbr stays 1.
- Even parity, 2 stop bits: write 0x07 -> start, bits 1,1,1,0,0,0,0,0, parity 1, stop 1,1; total 192 ticks.
- Odd parity: write 0x03 -> parity bit 1.
- Back-to-back frames: write 0xA5, 0x3C, 0xFF in consecutive cycles -> three frames with no idle bit between them; tbr remains 1 throughout (depth 4).
- Overflow: write 6 bytes in consecutive cycles while the first frame is still in START -> byte 1 is in the shift register, bytes 2-5 fill the FIFO (tbr=0), byte 6 is dropped with a single ovf pulse; exactly 5 frames are transmitted.
- Config change and reset: toggle parity_en mid-frame -> current frame is unaffected, next frame uses the new setting; assert rst_n=0 during DATA -> TxD=1 asynchronously and FIFO empty; after release, tbr=1, busy=0, and a new write produces a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Frame length in baud ticks for a given format.
  function automatic int unsigned frame_ticks(input int unsigned oversample,
                                              input int unsigned data_bits,
                                              input logic        parity_en,
                                              input logic        two_stop);
    return oversample * (32'd2 + data_bits + 32'(parity_en) + 32'(two_stop));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head-of-queue read data visible while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with configurable parity and stop bits.
//
// state  | meaning
// IDLE   | line idle at 1, waiting for FIFO data
// START  | start bit (0) for one bit time
// DATA   | data bits, LSB first, from the shift register
// PARITY | parity bit computed when the byte was popped
// STOP   | one or two stop bits (1); pops the next byte with no idle gap
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tbr,
  output logic                 busy,
  output logic                 ovf,
  output logic                 TxD
);

  localparam int                TICK_W      = $clog2(OVERSAMPLE);
  localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_RELOAD  = 3'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_bit_q, par_bit_d;
  logic                   cfg_par_en_q, cfg_par_en_d;
  logic                   cfg_two_stop_q, cfg_two_stop_d;
  logic                   txd_q, txd_d;
  logic                   ovf_q, ovf_d;

  logic                   pop, load;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (wr_en),
    .wr_data_i (data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign tbr  = !fifo_full;
  assign busy = (state_q != IDLE) || (fifo_count != '0);
  assign ovf  = ovf_q;
  assign TxD  = txd_q;

  // Next-state logic: bit timing on en ticks, frame load on pop, line level from next state.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    bit_d          = bit_q;
    shreg_d        = shreg_q;
    par_bit_d      = par_bit_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_two_stop_d = cfg_two_stop_q;
    load           = 1'b0;
    pop            = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (en) begin
          if (tick_q == '0) begin
            state_d = DATA;
            tick_d  = TICK_RELOAD;
            bit_d   = BIT_RELOAD;
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (en) begin
          if (tick_q == '0) begin
            tick_d = TICK_RELOAD;
            if (bit_q == '0) begin
              state_d = cfg_par_en_q ? PARITY : STOP;
              bit_d   = {2'b00, cfg_two_stop_q};
            end else begin
              bit_d   = bit_q - 3'd1;
              shreg_d = shreg_q >> 1;
            end
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
      end
      PARITY: begin
        if (en) begin
          if (tick_q == '0) begin
            state_d = STOP;
            tick_d  = TICK_RELOAD;
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (en) begin
          if (tick_q == '0) begin
            if (bit_q != '0) begin
              bit_d  = bit_q - 3'd1;
              tick_d = TICK_RELOAD;
            end else if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame format is captured with the byte so later config changes cannot corrupt it.
    if (load) begin
      pop            = 1'b1;
      state_d        = START;
      tick_d         = TICK_RELOAD;
      shreg_d        = fifo_rd_data;
      par_bit_d      = (^fifo_rd_data) ^ parity_odd;
      cfg_par_en_d   = parity_en;
      cfg_two_stop_d = two_stop;
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = TX_IDLE_LEVEL;
    endcase

    ovf_d = wr_en && fifo_full && !pop;
  end

  // State and output registers; reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      bit_q          <= '0;
      shreg_q        <= '0;
      par_bit_q      <= 1'b0;
      cfg_par_en_q   <= 1'b0;
      cfg_two_stop_q <= 1'b0;
      txd_q          <= TX_IDLE_LEVEL;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      par_bit_q      <= par_bit_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_two_stop_q <= cfg_two_stop_d;
      txd_q          <= txd_d;
      ovf_q          <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frames are decoded from TxD at each en tick and
// compared with frames built from the written bytes and format settings.
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       ts;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       tbr, busy, ovf, TxD;

  frame_t     exp_q[$];
  logic [7:0] burst_data [8];
  int         n_checks = 0;
  int         n_errors = 0;
  int         frames_done = 0;
  int         ovf_cnt = 0;
  int         en_mode = 1;
  logic       in_frame = 1'b0;
  logic       gap_pending = 1'b0;
  int         bit_idx = 0;

  uart_tx_fifo #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .data       (data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tbr        (tbr),
    .busy       (busy),
    .ovf        (ovf),
    .TxD        (TxD)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Baud tick generator: every cycle, 1-in-4, or 1-in-2 on average.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 3) == 0);
        default: en = ($urandom_range(0, 1) == 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ovf) ovf_cnt++;
    end
  end

  // Line decoder: each bit must read the same value on exactly OS en ticks.
  initial begin : monitor
    frame_t      cur;
    logic [15:0] bits;
    int          nbits, samp, ones;
    logic        busy_ok;
    nbits = 0; samp = 0; ones = 0; busy_ok = 1'b1; bits = '1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame    = 1'b0;
        gap_pending = 1'b0;
      end else if (en) begin
        if (!in_frame) begin
          if (gap_pending) begin
            check_eq("gap_level", int'(TxD), (exp_q.size() != 0) ? 0 : 1);
            check_eq("busy_after_frame", int'(busy), (exp_q.size() != 0) ? 1 : 0);
            gap_pending = 1'b0;
          end
          if (TxD == 1'b0) begin
            if (exp_q.size() == 0) begin
              check_eq("spurious_start", int'(TxD), 1);
            end else begin
              cur  = exp_q.pop_front();
              bits = '1;
              bits[0] = 1'b0;
              for (int i = 0; i < DB; i++) bits[1+i] = cur.d[i];
              if (cur.pe) bits[1+DB] = (^cur.d) ^ cur.po;
              nbits    = 2 + DB + int'(cur.pe) + int'(cur.ts);
              in_frame = 1'b1;
              bit_idx  = 0;
              samp     = 0;
              ones     = 0;
              busy_ok  = 1'b1;
            end
          end
        end
        if (in_frame) begin
          samp++;
          ones += int'(TxD);
          if (!busy) busy_ok = 1'b0;
          if (samp == OS) begin
            check_eq($sformatf("frame%0d_bit%0d", frames_done, bit_idx),
                     (ones == OS) ? 1 : ((ones == 0) ? 0 : 2), int'(bits[bit_idx]));
            bit_idx++;
            samp = 0;
            ones = 0;
            if (bit_idx == nbits) begin
              check_eq("busy_in_frame", int'(busy_ok), 1);
              in_frame    = 1'b0;
              gap_pending = 1'b1;
              frames_done++;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || in_frame || gap_pending || busy) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("idle_reached", int'(cyc < 20000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bit(input int fr, input int b);
    int cyc;
    cyc = 0;
    while (!(frames_done >= fr && in_frame && bit_idx >= b) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bit_reached", int'(cyc < 20000), 1);
  endtask

  task automatic set_cfg(input logic pe, input logic po, input logic ts);
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
  endtask

  // Burst of n writes from idle: the first byte goes straight to the shift
  // register, the next DEPTH fill the FIFO, anything beyond is dropped.
  task automatic run_burst(input int n);
    int acc, ov0, f0;
    acc = (n < DEPTH + 1) ? n : DEPTH + 1;
    ov0 = ovf_cnt;
    f0  = frames_done;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      data  = burst_data[i];
      if (i < acc) exp_q.push_back('{burst_data[i], parity_en, parity_odd, two_stop});
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check_eq("tbr_after_burst", int'(tbr), (acc - 1 < DEPTH) ? 1 : 0);
    repeat (2) @(negedge clk);
    check_eq("ovf_pulses", ovf_cnt - ov0, n - acc);
    wait_idle();
    check_eq("frames_sent", frames_done - f0, acc);
  endtask

  task automatic write_one(input logic [7:0] b);
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    data  = b;
    exp_q.push_back('{b, parity_en, parity_odd, two_stop});
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin : stim
    int f0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_txd", int'(TxD), 1);
    check_eq("rst_tbr", int'(tbr), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0x55
    set_cfg(1'b0, 1'b0, 1'b0);
    burst_data[0] = 8'h55;
    run_burst(1);

    // even parity, two stop bits, 0x07
    set_cfg(1'b1, 1'b0, 1'b1);
    burst_data[0] = 8'h07;
    run_burst(1);

    // odd parity, 0x03
    set_cfg(1'b1, 1'b1, 1'b0);
    burst_data[0] = 8'h03;
    run_burst(1);

    // back-to-back frames
    set_cfg(1'b0, 1'b0, 1'b0);
    burst_data[0] = 8'hA5;
    burst_data[1] = 8'h3C;
    burst_data[2] = 8'hFF;
    run_burst(3);

    // overflow: six writes, last one dropped
    for (int i = 0; i < 6; i++) burst_data[i] = 8'($urandom);
    run_burst(6);

    // format change mid-frame only affects the next popped frame
    f0 = frames_done;
    set_cfg(1'b0, 1'b0, 1'b0);
    write_one(8'h96);
    wait_bit(f0, 2);
    set_cfg(1'b1, 1'b1, 1'b0);
    write_one(8'h4B);
    wait_bit(f0 + 1, 2);
    set_cfg(1'b0, 1'b0, 1'b1);
    wait_idle();
    check_eq("cfg_frames", frames_done - f0, 2);

    // reset in the middle of DATA while a second byte is queued
    set_cfg(1'b0, 1'b0, 1'b0);
    f0 = frames_done;
    write_one(8'h5A);
    write_one(8'hC3);
    wait_bit(f0, 3);
    @(posedge clk);
    #2;
    check_eq("txd_before_rst", int'(TxD), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_txd", int'(TxD), 1);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_tbr", int'(tbr), 1);
    check_eq("midrst_ovf", int'(ovf), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_tbr", int'(tbr), 1);
    check_eq("post_rst_busy", int'(busy), 0);
    set_cfg(1'b1, 1'b0, 1'b0);
    burst_data[0] = 8'h3E;
    run_burst(1);

    // randomized formats, burst lengths and tick rates
    for (int it = 0; it < 6; it++) begin
      en_mode = int'($urandom_range(0, 2));
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++) burst_data[i] = 8'($urandom);
      run_burst(int'($urandom_range(1, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
